// File: rtl/mux_arb_pkg.sv
// Shared types and sizing for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } arb_state_t;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_REQ-1:0] req_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant/select bundle between the four requesters and the arbiter.
// The lock signal exists only when ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if;
    import mux_arb_pkg::*;

    req_t req;
    req_t grant;
    sel_t sel;
    logic valid;

`ifdef ARB_LOCK_EN
    logic lock;

    modport master (input req, input lock, output grant, output sel, output valid);
    modport slave  (output req, output lock, input grant, input sel, input valid);
`else
    modport master (input req, output grant, output sel, output valid);
    modport slave  (output req, input grant, input sel, input valid);
`endif

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first requester after 'last', wrapping modulo N_REQ.
module rr_pick
    import mux_arb_pkg::*;
(
    input  req_t req,
    input  sel_t last,
    output logic any,
    output sel_t pick
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        any  = |req;
        pick = last;
        // Walk from farthest to nearest so the nearest requester wins the final overwrite.
        for (int k = N_REQ; k >= 1; k--) begin
            sel_t idx;
            idx = last + sel_t'(k);
            if (req[idx]) pick = idx;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select with bounded hold and one-cycle turnaround.
// Optional lock input (suppresses hold-limit preemption) under macro ARB_LOCK_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input logic            clk,
    input logic            rst_n,
    mux_rr_arbiter_if.master bus
);

    localparam int                HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state, state_nx;
    req_t              grant_q, grant_nx;
    sel_t              sel_q, sel_nx;
    logic              valid_q, valid_nx;
    sel_t              last_q, last_nx;
    logic [HOLD_W-1:0] hold_q, hold_nx;

    logic any;
    sel_t pick;
    logic release_req;
    logic others_req;
    logic at_limit;
    logic preempt_ok;

    rr_pick u_pick (
        .req  (bus.req),
        .last (last_q),
        .any  (any),
        .pick (pick)
    );

`ifdef ARB_LOCK_EN
    assign preempt_ok = !bus.lock;
`else
    assign preempt_ok = 1'b1;
`endif

    // While granted, last_q is the owner, so its request line is the release indicator.
    assign release_req = !bus.req[last_q];
    assign others_req  = |(bus.req & ~grant_q);
    assign at_limit    = (hold_q == HOLD_MAX);

    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        sel_nx   = sel_q;
        valid_nx = valid_q;
        last_nx  = last_q;
        hold_nx  = hold_q;
        case (state)
            IDLE, TURN: begin
                if (any) begin
                    state_nx = GRANT;
                    grant_nx = req_t'(1) << pick;
                    sel_nx   = pick;
                    valid_nx = 1'b1;
                    last_nx  = pick;
                    hold_nx  = '0;
                end else begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    valid_nx = 1'b0;
                end
            end
            GRANT: begin
                if (release_req || (at_limit && others_req && preempt_ok)) begin
                    state_nx = TURN;
                    grant_nx = '0;
                    valid_nx = 1'b0;
                end else if (!at_limit) begin
                    hold_nx = hold_q + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= sel_t'(N_REQ - 1);
            hold_q  <= '0;
        end else begin
            state   <= state_nx;
            grant_q <= grant_nx;
            sel_q   <= sel_nx;
            valid_q <= valid_nx;
            last_q  <= last_nx;
            hold_q  <= hold_nx;
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed testbench for mux_rr_arbiter; lock scenario runs only with ARB_LOCK_EN.
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mux_rr_arbiter_if arb_if ();

    mux_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (arb_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        arb_if.req = 4'b1111;
        tick();
        tick();
        total++;
        if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0000, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: grant=%b sel=%0d valid=%b want grant=0000 sel=0 valid=0",
                     arb_if.grant, arb_if.sel, arb_if.valid);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0001, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_first_grant: grant=%b sel=%0d valid=%b want grant=0001 sel=0 valid=1",
                     arb_if.grant, arb_if.sel, arb_if.valid);
        end
    endtask

    // Starts on the first observed cycle of owner 0 with req=1111 held.
    task automatic test_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        for (int o = 0; o < 5; o++) begin
            logic [3:0] g_exp;
            g_exp = 4'b0001 << order[o];
            for (int c = 0; c < 8; c++) begin
                total++;
                if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {g_exp, 2'(order[o]), 1'b1}) begin
                    bad++;
                    $display("FAIL rotation_grant o=%0d c=%0d: grant=%b sel=%0d valid=%b want grant=%b sel=%0d valid=1",
                             o, c, arb_if.grant, arb_if.sel, arb_if.valid, g_exp, order[o]);
                end
                tick();
            end
            total++;
            if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0000, 2'(order[o]), 1'b0}) begin
                bad++;
                $display("FAIL rotation_turn o=%0d: grant=%b sel=%0d valid=%b want grant=0000 sel=%0d valid=0",
                         o, arb_if.grant, arb_if.sel, arb_if.valid, order[o]);
            end
            if (o < 4) tick();
        end
        arb_if.req = 4'b0000;
        tick();
    endtask

    task automatic test_release();
        arb_if.req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0100, 2'd2, 1'b1}) begin
                bad++;
                $display("FAIL release_grant c=%0d: grant=%b sel=%0d valid=%b want grant=0100 sel=2 valid=1",
                         c, arb_if.grant, arb_if.sel, arb_if.valid);
            end
        end
        arb_if.req = 4'b0000;
        tick();
        total++;
        if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0000, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL release_turn: grant=%b sel=%0d valid=%b want grant=0000 sel=2 valid=0",
                     arb_if.grant, arb_if.sel, arb_if.valid);
        end
        tick();
        total++;
        if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0000, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL release_idle: grant=%b sel=%0d valid=%b want grant=0000 sel=2 valid=0",
                     arb_if.grant, arb_if.sel, arb_if.valid);
        end
        arb_if.req = 4'b0001;
        tick();
        total++;
        if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0001, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL release_regrant: grant=%b sel=%0d valid=%b want grant=0001 sel=0 valid=1",
                     arb_if.grant, arb_if.sel, arb_if.valid);
        end
        arb_if.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_solo_hold();
        arb_if.req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0010, 2'd1, 1'b1}) begin
                bad++;
                $display("FAIL solo_hold c=%0d: grant=%b sel=%0d valid=%b want grant=0010 sel=1 valid=1",
                         c, arb_if.grant, arb_if.sel, arb_if.valid);
            end
        end
        arb_if.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_release_preempt();
        arb_if.req = 4'b0001;
        tick();
        arb_if.req = 4'b0101;
        for (int c = 1; c < 8; c++) begin
            tick();
            total++;
            if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0001, 2'd0, 1'b1}) begin
                bad++;
                $display("FAIL relpre_hold c=%0d: grant=%b sel=%0d valid=%b want grant=0001 sel=0 valid=1",
                         c, arb_if.grant, arb_if.sel, arb_if.valid);
            end
        end
        arb_if.req = 4'b0100;
        tick();
        total++;
        if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0000, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL relpre_turn: grant=%b sel=%0d valid=%b want grant=0000 sel=0 valid=0",
                     arb_if.grant, arb_if.sel, arb_if.valid);
        end
        tick();
        total++;
        if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0100, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL relpre_next: grant=%b sel=%0d valid=%b want grant=0100 sel=2 valid=1",
                     arb_if.grant, arb_if.sel, arb_if.valid);
        end
        arb_if.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        arb_if.req = 4'b1000;
        tick();
        total++;
        if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b1000, 2'd3, 1'b1}) begin
            bad++;
            $display("FAIL midrst_grant: grant=%b sel=%0d valid=%b want grant=1000 sel=3 valid=1",
                     arb_if.grant, arb_if.sel, arb_if.valid);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0000, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL midrst_drop: grant=%b sel=%0d valid=%b want grant=0000 sel=0 valid=0",
                     arb_if.grant, arb_if.sel, arb_if.valid);
        end
        rst_n      = 1'b1;
        arb_if.req = 4'b0000;
        tick();
        total++;
        if ({arb_if.grant, arb_if.valid} !== {4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL midrst_idle: grant=%b valid=%b want grant=0000 valid=0",
                     arb_if.grant, arb_if.valid);
        end
    endtask

`ifdef ARB_LOCK_EN
    // Runs right after a reset, so last=3 and owner 0 wins first.
    task automatic test_lock();
        arb_if.req  = 4'b0011;
        arb_if.lock = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            total++;
            if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0001, 2'd0, 1'b1}) begin
                bad++;
                $display("FAIL lock_hold c=%0d: grant=%b sel=%0d valid=%b want grant=0001 sel=0 valid=1",
                         c, arb_if.grant, arb_if.sel, arb_if.valid);
            end
        end
        arb_if.lock = 1'b0;
        tick();
        total++;
        if ({arb_if.grant, arb_if.valid} !== {4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL lock_turn: grant=%b valid=%b want grant=0000 valid=0",
                     arb_if.grant, arb_if.valid);
        end
        tick();
        total++;
        if ({arb_if.grant, arb_if.sel, arb_if.valid} !== {4'b0010, 2'd1, 1'b1}) begin
            bad++;
            $display("FAIL lock_next: grant=%b sel=%0d valid=%b want grant=0010 sel=1 valid=1",
                     arb_if.grant, arb_if.sel, arb_if.valid);
        end
        arb_if.req = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        arb_if.req = 4'b0000;
`ifdef ARB_LOCK_EN
        arb_if.lock = 1'b0;
`endif
        test_reset();
        test_rotation();
        test_release();
        test_solo_hold();
        test_release_preempt();
        test_reset_mid_grant();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
